// File: rtl/mitll_splitt_sched.sv
// Round-robin scheduler that shares one toggle-coded splitter among NREQ requesters.
// Fires one input event per grant, waits for both output toggles, then enforces a hold-off.

module mitll_splitt_sched_ch (
  input  logic clk,
  input  logic rst,
  input  logic mon,
  input  logic arm,
  input  logic track,
  output logic tog,
  output logic seen
);
  logic mon_q;

  // The edge reference follows the line even during reset, so releasing reset never looks like a toggle.
  always_ff @(posedge clk) begin
    mon_q <= mon;
    if (rst)        seen <= 1'b0;
    else if (arm)   seen <= 1'b0;
    else if (track) seen <= seen | tog;
  end

  assign tog = mon ^ mon_q;
endmodule

module mitll_splitt_sched #(
  parameter int NREQ     = 4,
  parameter int FIRE_LAT = 6,
  parameter int CT_CYC   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic            split_in,
  input  logic            out1_mon,
  input  logic            out2_mon,
  output logic            busy,
  output logic            err,
  output logic [7:0]      err_cnt
);
  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(FIRE_LAT) + 1;
  localparam int HW = $clog2(CT_CYC) + 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr, g_idx, pick_idx, cand;
  logic          pick_vld;
  logic [TW-1:0] timer;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    mon_vec, tog, seen;
  logic          arm, track, complete, timeout, err_ev;

  function automatic int wrap(input int a);
    return (a >= NREQ) ? a - NREQ : a;
  endfunction

  assign mon_vec = {out2_mon, out1_mon};
  assign arm     = (state == IDLE) && pick_vld;
  assign track   = (state == WAIT);

  genvar c;
  generate
    for (c = 0; c < 2; c++) begin : g_ch
      mitll_splitt_sched_ch u_ch (
        .clk  (clk),
        .rst  (rst),
        .mon  (mon_vec[c]),
        .arm  (arm),
        .track(track),
        .tog  (tog[c]),
        .seen (seen[c])
      );
    end
  endgenerate

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'(wrap(int'(rr_ptr) + i));
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // A toggle arriving in the exit cycle still counts toward completion.
  assign complete = (seen[0] | tog[0]) & (seen[1] | tog[1]);
  assign timeout  = (timer == TW'(FIRE_LAT - 1)) && !complete;
  assign err_ev   = ((state != WAIT) && (|tog)) ||
                    ((state == WAIT) && ((|(tog & seen)) || timeout));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      done     <= '0;
      split_in <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
      rr_ptr   <= '0;
      g_idx    <= '0;
      timer    <= '0;
      hold_cnt <= '0;
    end else begin
      done <= '0;
      if (err_ev) begin
        err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant    <= ONE << pick_idx;
            g_idx    <= pick_idx;
            split_in <= ~split_in;
            timer    <= '0;
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (complete || timeout) begin
            done     <= grant;
            grant    <= '0;
            rr_ptr   <= (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + 1'b1;
            hold_cnt <= '0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HW'(CT_CYC - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mitll_splitt_sched.sv
// Scoreboard bench for mitll_splitt_sched: directed stimulus pushes expected done events,
// a forked monitor pops and compares them whenever done pulses.

module tb_mitll_splitt_sched;
  localparam int NREQ = 4, FIRE_LAT = 6, CT_CYC = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant, done;
  logic            split_in, out1_mon, out2_mon, busy, err;
  logic [7:0]      err_cnt;

  typedef struct packed {
    logic [3:0] d;
    logic       e;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   tests, fails;
  logic en1, en2;
  int   inj1, inj2;
  int   lat;

  mitll_splitt_sched #(.NREQ(NREQ), .FIRE_LAT(FIRE_LAT), .CT_CYC(CT_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .done(done), .split_in(split_in),
    .out1_mon(out1_mon), .out2_mon(out2_mon), .busy(busy), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Splitter model: both outputs toggle 3 cycles after each input event; extra toggles on demand.
  initial begin
    logic prev;
    int   cnt, s1, s2;
    out1_mon = 1'b0; out2_mon = 1'b0; prev = 1'b0; cnt = 0; s1 = 0; s2 = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cnt  = 0;
        prev = split_in;
      end else if (split_in !== prev) begin
        prev = split_in;
        cnt  = 3;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (en1) out1_mon = ~out1_mon;
          if (en2) out2_mon = ~out2_mon;
        end
      end
      if (inj1 != s1) begin s1++; out1_mon = ~out1_mon; end
      if (inj2 != s2) begin s2++; out2_mon = ~out2_mon; end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic e, input logic [7:0] cnt);
    exp_t x;
    x.d = d; x.e = e; x.cnt = cnt;
    sb.push_back(x);
  endtask

  task automatic monitor();
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && done !== '0) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got %b, required no done", done);
        end else begin
          x = sb.pop_front();
          chk("done_bits", 32'(done), 32'(x.d));
          chk("done_err", 32'(err), 32'(x.e));
          chk("done_err_cnt", 32'(err_cnt), 32'(x.cnt));
          chk("grant_at_done", 32'(grant), 32'h0);
        end
      end
    end
  endtask

  // Raise a one-hot request, check the grant one cycle later, hold until done, return latency.
  task automatic serve(input logic [3:0] mask, input int inj_at, output int l);
    logic si_exp;
    l      = 0;
    si_exp = ~split_in;
    req    = mask;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("grant_after_req", 32'(grant), 32'(mask));
        chk("split_in_toggled", 32'(split_in), 32'(si_exp));
        chk("busy_in_wait", 32'(busy), 32'h1);
      end
      if (i == inj_at) inj1++;
      if (done !== '0) begin
        l = i;
        break;
      end
    end
    req = '0;
    if (l == 0) begin
      tests++;
      fails++;
      $display("FAIL done_wait: got no done in 30 cycles, required done pulse");
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int   ndone, ng, gap;
    logic [3:0] prevg;
    logic si;
    tests = 0; fails = 0;
    rst = 1'b1; req = '0; en1 = 1'b1; en2 = 1'b1; inj1 = 0; inj2 = 0;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_split_in", 32'(split_in), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    rst = 1'b0;

    // T1 single request
    push(4'b0001, 1'b0, 8'd0);
    serve(4'b0001, 0, lat);
    chk("t1_latency", 32'(lat), 32'd5);
    wait_idle();
    chk("t1_err", 32'(err), 32'h0);

    // T2 round robin from a fresh pointer
    do_reset();
    push(4'b0001, 1'b0, 8'd0);
    push(4'b0010, 1'b0, 8'd0);
    push(4'b0100, 1'b0, 8'd0);
    push(4'b1000, 1'b0, 8'd0);
    push(4'b0001, 1'b0, 8'd0);
    req = 4'hF; ndone = 0; ng = 0; gap = 0; prevg = '0;
    for (int c = 0; c < 80 && ndone < 5; c++) begin
      @(negedge clk);
      if (grant != '0 && prevg == '0) begin
        chk("t2_grant_order", 32'(grant), 32'h1 << (ng % 4));
        if (ng > 0) chk("t2_gap_ok", 32'(gap >= CT_CYC), 32'h1);
        ng++;
        gap = 0;
      end else if (grant == '0) begin
        gap++;
      end
      prevg = grant;
      if (done != '0) ndone++;
    end
    req = '0;
    chk("t2_done_count", 32'(ndone), 32'd5);
    wait_idle();

    // T3 timeout: out2 never answers
    en2 = 1'b0;
    push(4'b0001, 1'b1, 8'd1);
    serve(4'b0001, 0, lat);
    chk("t3_latency", 32'(lat), 32'(FIRE_LAT + 1));
    chk("t3_hold_busy", 32'(busy), 32'h1);
    chk("t3_hold_grant", 32'(grant), 32'h0);
    wait_idle();
    chk("t3_err_sticky", 32'(err), 32'h1);
    en2 = 1'b1;

    // T5 reset in the middle of WAIT
    req = 4'b0100;
    @(negedge clk);
    chk("t5_grant_pre", 32'(grant), 32'b0100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_grant", 32'(grant), 32'h0);
    chk("t5_done", 32'(done), 32'h0);
    chk("t5_split_in", 32'(split_in), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_err_cnt", 32'(err_cnt), 32'h0);
    chk("t5_err", 32'(err), 32'h0);
    rst = 1'b0;
    push(4'b0010, 1'b0, 8'd0);
    serve(4'b0010, 0, lat);
    chk("t5_latency", 32'(lat), 32'd5);
    wait_idle();

    // T4 spurious toggle while idle, then a double out1 toggle during WAIT
    si = split_in;
    inj1++;
    repeat (2) @(negedge clk);
    chk("t4_err", 32'(err), 32'h1);
    chk("t4_err_cnt", 32'(err_cnt), 32'd1);
    chk("t4_grant", 32'(grant), 32'h0);
    chk("t4_split_in", 32'(split_in), 32'(si));
    chk("t4_busy", 32'(busy), 32'h0);
    push(4'b1000, 1'b1, 8'd2);
    serve(4'b1000, 1, lat);
    chk("t4_latency", 32'(lat), 32'd5);
    wait_idle();

    // T6 one increment per cycle even with both outputs toggling, then saturation
    repeat (5) begin
      inj1++;
      inj2++;
      @(negedge clk);
    end
    @(negedge clk);
    chk("t6_one_per_cycle", 32'(err_cnt), 32'd7);
    repeat (300) begin
      inj1++;
      @(negedge clk);
    end
    @(negedge clk);
    chk("t6_saturated", 32'(err_cnt), 32'd255);
    chk("t6_err", 32'(err), 32'h1);
    chk("t6_grant", 32'(grant), 32'h0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
